// File: rtl/pipeline.sv
// Exact Othello endgame solver: negamax alpha-beta over an explicit frame stack.
// One stack action (evaluate, push, child-return update or pop) per clock in SEARCH.
module pipeline #(
    parameter int unsigned MAX_DEPTH = 20
) (
    input  logic               iCLOCK,
    input  logic               iRESET_N,
    input  logic               enable,
    input  logic [63:0]        iPlayer,
    input  logic [63:0]        iOpponent,
    output logic               solved,
    output logic [4:0]         o,
    output logic signed [7:0]  res
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic signed [7:0] SCORE_MIN = -8'sd64;
    localparam logic signed [7:0] SCORE_MAX = 8'sd64;
    localparam logic [63:0] NOT_COL0 = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] NOT_COL7 = 64'h7F7F_7F7F_7F7F_7F7F;

    function automatic logic [63:0] shift_dir(input logic [63:0] x, input int unsigned d);
        case (d)
            0:       return x << 8;
            1:       return x >> 8;
            2:       return (x << 1) & NOT_COL0;
            3:       return (x >> 1) & NOT_COL7;
            4:       return (x << 9) & NOT_COL0;
            5:       return (x << 7) & NOT_COL7;
            6:       return (x >> 7) & NOT_COL0;
            default: return (x >> 9) & NOT_COL7;
        endcase
    endfunction

    function automatic logic [63:0] legal_moves(input logic [63:0] p, input logic [63:0] q);
        logic [63:0] t;
        logic [63:0] m;
        m = '0;
        for (int unsigned d = 0; d < 8; d++) begin
            t = shift_dir(p, d) & q;
            for (int unsigned k = 0; k < 5; k++) t = t | (shift_dir(t, d) & q);
            m = m | (shift_dir(t, d) & ~(p | q));
        end
        return m;
    endfunction

    // The run grows only contiguously from sq, so shift(run)&p can only hit the closing disc.
    function automatic logic [63:0] flip_mask(input logic [63:0] p, input logic [63:0] q,
                                             input logic [63:0] sq);
        logic [63:0] t;
        logic [63:0] f;
        f = '0;
        for (int unsigned d = 0; d < 8; d++) begin
            t = shift_dir(sq, d) & q;
            for (int unsigned k = 0; k < 5; k++) t = t | (shift_dir(t, d) & q);
            if ((shift_dir(t, d) & p) != '0) f = f | t;
        end
        return f;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] x);
        logic [6:0] c;
        c = '0;
        for (int unsigned i = 0; i < 64; i++) c = c + 7'(x[i]);
        return c;
    endfunction

    function automatic logic signed [7:0] leaf_value(input logic [63:0] p, input logic [63:0] q);
        logic signed [7:0] np;
        logic signed [7:0] nq;
        logic signed [7:0] diff;
        logic signed [7:0] empties;
        np      = $signed({1'b0, popcount(p)});
        nq      = $signed({1'b0, popcount(q)});
        diff    = np - nq;
        empties = 8'sd64 - np - nq;
        if (diff > 0) return diff + empties;
        if (diff < 0) return diff - empties;
        return '0;
    endfunction

    state_t            state_q, state_d;
    logic [4:0]        sp_q, sp_d;
    logic              ret_valid_q, ret_valid_d;
    logic signed [7:0] ret_val_q, ret_val_d;
    logic signed [7:0] res_q, res_d;

    logic [63:0]       p_q     [MAX_DEPTH];
    logic [63:0]       p_d     [MAX_DEPTH];
    logic [63:0]       opp_q   [MAX_DEPTH];
    logic [63:0]       opp_d   [MAX_DEPTH];
    logic [63:0]       mov_q   [MAX_DEPTH];
    logic [63:0]       mov_d   [MAX_DEPTH];
    logic signed [7:0] alpha_q [MAX_DEPTH];
    logic signed [7:0] alpha_d [MAX_DEPTH];
    logic signed [7:0] beta_q  [MAX_DEPTH];
    logic signed [7:0] beta_d  [MAX_DEPTH];
    logic signed [7:0] best_q  [MAX_DEPTH];
    logic signed [7:0] best_d  [MAX_DEPTH];
    logic              fresh_q [MAX_DEPTH];
    logic              fresh_d [MAX_DEPTH];
    logic              pass_q  [MAX_DEPTH];
    logic              pass_d  [MAX_DEPTH];

    logic [4:0]        top, nxt;
    logic              at_max;
    logic [63:0]       cur_p, cur_o, cur_mov;
    logic [63:0]       legal_p, legal_o, sq, flip;
    logic signed [7:0] score, leaf;
    logic              pop;
    logic signed [7:0] pop_val;

    always_comb begin
        top     = sp_q;
        nxt     = sp_q + 5'd1;
        at_max  = (sp_q == 5'(MAX_DEPTH - 1));
        cur_p   = p_q[top];
        cur_o   = opp_q[top];
        cur_mov = mov_q[top];
        legal_p = legal_moves(cur_p, cur_o);
        legal_o = legal_moves(cur_o, cur_p);
        sq      = cur_mov & (~cur_mov + 64'd1);
        flip    = flip_mask(cur_p, cur_o, sq);
        score   = -ret_val_q;
        leaf    = leaf_value(cur_p, cur_o);
    end

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        ret_valid_d = ret_valid_q;
        ret_val_d   = ret_val_q;
        res_d       = res_q;
        p_d         = p_q;
        opp_d       = opp_q;
        mov_d       = mov_q;
        alpha_d     = alpha_q;
        beta_d      = beta_q;
        best_d      = best_q;
        fresh_d     = fresh_q;
        pass_d      = pass_q;
        pop         = 1'b0;
        pop_val     = '0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d     = SEARCH;
                    sp_d        = '0;
                    ret_valid_d = 1'b0;
                    res_d       = '0;
                    p_d[0]      = iPlayer;
                    opp_d[0]    = iOpponent & ~iPlayer;
                    mov_d[0]    = '0;
                    alpha_d[0]  = SCORE_MIN;
                    beta_d[0]   = SCORE_MAX;
                    best_d[0]   = SCORE_MIN;
                    fresh_d[0]  = 1'b1;
                    pass_d[0]   = 1'b0;
                end
            end
            SEARCH: begin
                if (ret_valid_q) begin
                    ret_valid_d = 1'b0;
                    if (score > best_q[top])  best_d[top]  = score;
                    if (score > alpha_q[top]) alpha_d[top] = score;
                end else if (fresh_q[top]) begin
                    fresh_d[top] = 1'b0;
                    // A full stack is treated as a leaf so the search still terminates.
                    if (at_max) begin
                        pop     = 1'b1;
                        pop_val = leaf;
                    end else if (legal_p != '0) begin
                        mov_d[top] = legal_p;
                    end else if (legal_o != '0) begin
                        pass_d[top]   = 1'b1;
                        sp_d          = nxt;
                        p_d[nxt]      = cur_o;
                        opp_d[nxt]    = cur_p;
                        mov_d[nxt]    = '0;
                        alpha_d[nxt]  = -beta_q[top];
                        beta_d[nxt]   = -alpha_q[top];
                        best_d[nxt]   = SCORE_MIN;
                        fresh_d[nxt]  = 1'b1;
                        pass_d[nxt]   = 1'b0;
                    end else begin
                        pop     = 1'b1;
                        pop_val = leaf;
                    end
                end else if (pass_q[top] || (cur_mov == '0) || (alpha_q[top] >= beta_q[top])) begin
                    pop     = 1'b1;
                    pop_val = best_q[top];
                end else begin
                    mov_d[top]    = cur_mov & ~sq;
                    sp_d          = nxt;
                    p_d[nxt]      = cur_o ^ flip;
                    opp_d[nxt]    = cur_p | flip | sq;
                    mov_d[nxt]    = '0;
                    alpha_d[nxt]  = -beta_q[top];
                    beta_d[nxt]   = -alpha_q[top];
                    best_d[nxt]   = SCORE_MIN;
                    fresh_d[nxt]  = 1'b1;
                    pass_d[nxt]   = 1'b0;
                end

                if (pop) begin
                    if (top == '0) begin
                        state_d = DONE;
                        res_d   = pop_val;
                    end else begin
                        sp_d        = top - 5'd1;
                        ret_valid_d = 1'b1;
                        ret_val_d   = pop_val;
                    end
                end
            end
            DONE: begin
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            state_q     <= IDLE;
            sp_q        <= '0;
            ret_valid_q <= 1'b0;
            ret_val_q   <= '0;
            res_q       <= '0;
            for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
                p_q[i]     <= '0;
                opp_q[i]   <= '0;
                mov_q[i]   <= '0;
                alpha_q[i] <= '0;
                beta_q[i]  <= '0;
                best_q[i]  <= '0;
                fresh_q[i] <= 1'b0;
                pass_q[i]  <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            ret_valid_q <= ret_valid_d;
            ret_val_q   <= ret_val_d;
            res_q       <= res_d;
            p_q         <= p_d;
            opp_q       <= opp_d;
            mov_q       <= mov_d;
            alpha_q     <= alpha_d;
            beta_q      <= beta_d;
            best_q      <= best_d;
            fresh_q     <= fresh_d;
            pass_q      <= pass_d;
        end
    end

    assign solved = (state_q == DONE);
    assign o      = (state_q == SEARCH) ? sp_q : '0;
    assign res    = res_q;

endmodule

// File: tb/tb_pipeline.sv
// Bench for the Othello endgame solver: a plain full-width negamax model (ray walking,
// no pruning) computes every expected result; fixed positions pin the model itself.
module tb_pipeline;

    localparam logic [63:0] POS1_P = 64'h10B8_DDE3_B1B9_8284;
    localparam logic [63:0] POS1_O = 64'h8E45_221C_4E46_7C78;
    localparam int LIMIT = 60000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [63:0]       ip, io;
    logic              solved;
    logic [4:0]        o;
    logic signed [7:0] res;

    int checks = 0;
    int failures = 0;
    int exp_res = 0;
    int max_o = 0;

    pipeline #(.MAX_DEPTH(20)) dut (
        .iCLOCK(clk), .iRESET_N(rst_n), .enable(enable), .iPlayer(ip),
        .iOpponent(io), .solved(solved), .o(o), .res(res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [63:0] m_flips(input logic [63:0] p, input logic [63:0] q, input int s);
        logic [63:0] f;
        logic [63:0] run;
        int r, c;
        f = '0;
        if (p[s] || q[s]) return '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    run = '0;
                    r = s / 8 + dr;
                    c = s % 8 + dc;
                    while (r >= 0 && r < 8 && c >= 0 && c < 8 && q[r*8+c]) begin
                        run[r*8+c] = 1'b1;
                        r += dr;
                        c += dc;
                    end
                    if (run != '0 && r >= 0 && r < 8 && c >= 0 && c < 8 && p[r*8+c]) f |= run;
                end
            end
        end
        return f;
    endfunction

    function automatic bit m_can_move(input logic [63:0] p, input logic [63:0] q);
        for (int s = 0; s < 64; s++) if (m_flips(p, q, s) != '0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_leaf(input logic [63:0] p, input logic [63:0] q);
        int np, nq, d, e;
        np = $countones(p);
        nq = $countones(q);
        d = np - nq;
        e = 64 - np - nq;
        if (d > 0) return d + e;
        if (d < 0) return d - e;
        return 0;
    endfunction

    // Full negamax on an iterative stack: every move is explored, so no window is needed.
    function automatic int m_solve(input logic [63:0] p0, input logic [63:0] q0);
        logic [63:0] fp [64];
        logic [63:0] fq [64];
        int  fnext [64];
        int  fbest [64];
        bit  fany  [64];
        bit  fpass [64];
        int  sp, found, ret, result;
        bit  have_ret, do_pop;
        logic [63:0] f;
        sp = 0; fp[0] = p0; fq[0] = q0; fnext[0] = 0; fbest[0] = -1000;
        fany[0] = 0; fpass[0] = 0; have_ret = 0; result = 0; ret = 0;
        while (sp >= 0) begin
            do_pop = 0;
            if (have_ret) begin
                if (-ret > fbest[sp]) fbest[sp] = -ret;
                have_ret = 0;
            end
            found = -1;
            for (int s = fnext[sp]; s < 64 && found < 0; s++)
                if (m_flips(fp[sp], fq[sp], s) != '0) found = s;
            if (found >= 0) begin
                f = m_flips(fp[sp], fq[sp], found);
                fnext[sp] = found + 1;
                fany[sp] = 1;
                fp[sp+1] = fq[sp] ^ f;
                fq[sp+1] = fp[sp] | f | (64'd1 << found);
                sp++;
                fnext[sp] = 0; fbest[sp] = -1000; fany[sp] = 0; fpass[sp] = 0;
            end else if (fany[sp] || fpass[sp]) begin
                ret = fbest[sp];
                do_pop = 1;
            end else if (m_can_move(fq[sp], fp[sp])) begin
                fpass[sp] = 1;
                fp[sp+1] = fq[sp];
                fq[sp+1] = fp[sp];
                sp++;
                fnext[sp] = 0; fbest[sp] = -1000; fany[sp] = 0; fpass[sp] = 0;
            end else begin
                ret = m_leaf(fp[sp], fq[sp]);
                do_pop = 1;
            end
            if (do_pop) begin
                if (sp == 0) result = ret;
                have_ret = 1;
                sp--;
            end
        end
        return result;
    endfunction

    // Single compare process: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n && solved) begin
            chk("res_while_solved", int'(res), exp_res);
            chk("o_while_solved", int'(o), 0);
        end
        if (int'(o) > max_o) max_o = int'(o);
    end

    task automatic run_pos(input logic [63:0] p, input logic [63:0] q, input int expect_v,
                           input bit drop_en, output int cycles);
        int n;
        exp_res = expect_v;
        ip = p;
        io = q;
        enable = 1'b1;
        @(negedge clk);
        ip = {$urandom, $urandom};
        io = {$urandom, $urandom};
        if (drop_en) enable = 1'b0;
        n = 0;
        while (!solved && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        cycles = n;
        chk("solved_within_budget", int'(solved), 1);
        chk("res_final", int'(res), expect_v);
        if (!drop_en) begin
            @(negedge clk);
            chk("solved_held", int'(solved), 1);
            enable = 1'b0;
        end
        @(negedge clk);
        chk("solved_cleared", int'(solved), 0);
        chk("o_idle", int'(o), 0);
        chk("res_kept", int'(res), expect_v);
    endtask

    initial begin
        int cyc;
        logic [63:0] rp, rq, noise;
        int k, e;
        rst_n = 1'b0;
        enable = 1'b0;
        ip = '0;
        io = '0;
        repeat (3) @(negedge clk);
        chk("reset_solved", int'(solved), 0);
        chk("reset_o", int'(o), 0);
        chk("reset_res", int'(res), 0);
        rst_n = 1'b1;

        chk("model_pos1", m_solve(POS1_P, POS1_O), 16);
        chk("model_full", m_solve(64'hFFFF_FFFF_FF00_0000, 64'h0000_0000_00FF_FFFF), 16);
        chk("model_lone_player", m_solve(64'h1, 64'h0), 64);
        chk("model_lone_opp", m_solve(64'h0, 64'h1), -64);
        chk("model_corner", m_solve(~64'h3, 64'h2), 64);

        repeat (5) @(negedge clk);
        run_pos(POS1_P, POS1_O, 16, 1'b0, cyc);

        run_pos(64'hFFFF_FFFF_FF00_0000, 64'h0000_0000_00FF_FFFF, 16, 1'b0, cyc);
        chk("full_board_fast", int'(cyc <= 5), 1);

        run_pos(64'h1, 64'h0, 64, 1'b0, cyc);
        run_pos(64'h0, 64'h1, -64, 1'b0, cyc);

        max_o = 0;
        run_pos(~64'h3, 64'h2, 64, 1'b0, cyc);
        chk("corner_max_depth", max_o, 1);

        run_pos(POS1_P, POS1_O, 16, 1'b0, cyc);

        exp_res = 16;
        ip = POS1_P;
        io = POS1_O;
        enable = 1'b1;
        repeat (40) @(negedge clk);
        chk("still_searching", int'(solved), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_solved", int'(solved), 0);
        chk("abort_o", int'(o), 0);
        chk("abort_res", int'(res), 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_pos(POS1_P, POS1_O, 16, 1'b0, cyc);

        for (int t = 0; t < 12; t++) begin
            rp = {$urandom, $urandom};
            rq = ~rp;
            k = $urandom_range(5, 1);
            for (int j = 0; j < k; j++) begin
                e = $urandom_range(63, 0);
                rp[e] = 1'b0;
                rq[e] = 1'b0;
            end
            noise = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            run_pos(rp, rq | (rp & noise), m_solve(rp, rq), t[0], cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline.md
Name: pipeline

Overview:
- Exact Othello endgame solver.
- Takes a board position as two 64-bit bitboards, with the side to move as "player".
- Runs an exhaustive negamax alpha-beta search with an explicit on-chip stack.
- Reports the perfect-play final disc difference from the mover's view. Sits as the compute core behind a host or board-feeder interface.

Parameters:
- MAX_DEPTH, 20: stack frames, including pass frames. Positions needing more plies than this are unsupported.

Ports:
- iCLOCK  in  1  system clock; all state updates on the rising edge.
- iRESET_N  in  1  asynchronous active-low reset.
- enable  in  1  start/hold request.
- iPlayer  in  64  discs of the side to move. Bit i = row i/8, column i%8.
- iOpponent  in  64  discs of the other side, same bit mapping.
- solved  out  1  high while a valid result is held.
- o  out  5  current stack depth (debug/progress).
- res  out  8 signed  final disc difference, player minus opponent, range -64..64.

Behaviour:
- Reset (async, iRESET_N=0): state IDLE, solved=0, res=0, o=0, stack cleared. Reset mid-search aborts immediately.
- States:
  - IDLE -> SEARCH when enable=1. On that edge, latch P=iPlayer and O=iOpponent&~iPlayer (overlap resolved in player's favour). Push root frame: alpha=-64, beta=+64, depth 0.
  - SEARCH runs until the root frame returns, then goes to DONE.
  - DONE: res = root value, solved=1. Hold while enable=1. enable=0 -> IDLE, solved=0; res keeps its value until the next start.
- enable dropping during SEARCH is ignored; the search completes.
- Inputs are ignored except on the IDLE->SEARCH edge.
- Move generation (combinational, one cycle):
  - Legal mask = empty squares that bracket >=1 opponent disc in any of 8 directions.
  - Column-wrap masking is applied for E/W and diagonal shifts.
  - Flip mask for a chosen square is computed the same way. The new position is (O^flip, P|flip|sq), swapped to the new mover.
- Move order: ascending bit index. Each frame stores P, O, the remaining-legal mask, alpha, beta, best, and a pass flag.
- Per frame:
  - If legal moves exist, descend into the lowest remaining move. That is one push per cycle.
  - On child return with value v: score=-v; best=max(best,score); alpha=max(alpha,score).
  - If alpha>=beta (cutoff) or no moves remain, pop and return best.
- No legal moves, opponent has moves: push a pass frame with P/O swapped and the window negated (-beta,-alpha); negate its result on return.
- Neither side has moves: terminal. Value = popcount(P)-popcount(O). Empties go to the winner: add them if positive, subtract if negative; draw = 0.
- Terminal evaluation and pop take one cycle each.
- o = number of frames currently above root (0 in IDLE/DONE).
- Stack overflow beyond MAX_DEPTH is unsupported. Implementation must not wrap silently: clamp and still terminate.
- Latency: data-dependent. A 7-empty position must finish well under 10,000,000 cycles.
- res is signed two's complement 8-bit; internal scores are 8-bit signed.

Test Plan:
- P=0x10B8DDE3B1B98284, O=0x8E45221C4E467C78 (7 empties), enable after 5 idle cycles -> solved within 10M cycles, res=16.
- Full board P=0xFFFFFFFFFF000000, O=0x0000000000FFFFFF -> terminal at root, res=16, solved within ~5 cycles.
- P=0x0000000000000001, O=0 (neither side can move, 63 empties) -> res=64. Swap P and O -> res=-64.
- P=~0x3, O=0x2 (single empty at bit 0, move flips bit 1) -> res=64. Check o reaches 1 during search.
- After solved, drop enable -> solved=0 next cycle, o=0. Re-enable with the first test position -> res=16 again.
- Assert iRESET_N low mid-search on the first test position -> solved=0, o=0, res=0 immediately. Releasing it and re-enabling gives res=16.
